// File: rtl/sc_level_progress.sv
// Level/progress tracker: debounced active-low requests drive a 3-state machine
// that advances levels, steps progress manually or from a prescaled tick, and freezes on game over.
module sc_level_progress #(
  parameter int unsigned TICK_DIV     = 25000000,
  parameter int unsigned PROGRESS_MAX = 31
) (
  input  logic       SC_LEVEL_PROGRESS_CLOCK_50,
  input  logic       SC_LEVEL_PROGRESS_RESET_InLow,
  input  logic       SC_LEVEL_PROGRESS_Start_InLow,
  input  logic       SC_LEVEL_PROGRESS_upCount_InLow,
  input  logic       SC_LEVEL_PROGRESS_ProgressUpCount_InLow,
  input  logic       SC_LEVEL_PROGRESS_LevelEnd_InLow,
  input  logic       SC_LEVEL_PROGRESS_GameEnd_InLow,
  output logic [2:0] SC_LEVEL_PROGRESS_CurrentLevel_Out,
  output logic [4:0] SC_LEVEL_PROGRESS_ProgressCount_Out,
  output logic       SC_LEVEL_PROGRESS_Tick_Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned START = 0;
  localparam int unsigned UP    = 1;
  localparam int unsigned PU    = 2;
  localparam int unsigned LE    = 3;
  localparam int unsigned GE    = 4;

  localparam logic [25:0] PRESC_LAST = 26'(TICK_DIV - 32'd1);
  localparam logic [4:0]  PROG_MAX   = 5'(PROGRESS_MAX);

  function automatic logic [4:0] prog_sat_inc(input logic [4:0] v);
    prog_sat_inc = (v >= PROG_MAX) ? PROG_MAX : v + 5'd1;
  endfunction

  function automatic logic [2:0] level_sat_inc(input logic [2:0] v);
    level_sat_inc = (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

  logic [4:0]  raw_s;
  logic [4:0]  s1_r;
  logic [4:0]  s2_r;
  logic [4:0]  arm_r;
  logic [4:0]  ev_s;
  logic        wrap_s;
  logic        advance_s;
  logic        halt_s;

  state_t      state_r, state_s;
  logic [2:0]  level_r, level_s;
  logic [4:0]  prog_r, prog_s;
  logic [25:0] presc_r, presc_s;
  logic        tick_r, tick_s;

  assign raw_s = {SC_LEVEL_PROGRESS_GameEnd_InLow, SC_LEVEL_PROGRESS_LevelEnd_InLow,
                  SC_LEVEL_PROGRESS_ProgressUpCount_InLow, SC_LEVEL_PROGRESS_upCount_InLow,
                  SC_LEVEL_PROGRESS_Start_InLow};

  // arm_r blocks an input held low through reset from looking like a fresh request
  assign ev_s      = s2_r & ~s1_r & arm_r;
  assign wrap_s    = (presc_r == PRESC_LAST);
  assign advance_s = ev_s[UP] | ev_s[LE];
  assign halt_s    = ~s1_r[GE] | ev_s[GE];

  // Input sample chains and per-input arming
  always_ff @(posedge SC_LEVEL_PROGRESS_CLOCK_50 or negedge SC_LEVEL_PROGRESS_RESET_InLow) begin
    if (!SC_LEVEL_PROGRESS_RESET_InLow) begin
      s1_r  <= 5'b11111;
      s2_r  <= 5'b11111;
      arm_r <= 5'b00000;
    end else begin
      s1_r  <= raw_s;
      s2_r  <= s1_r;
      arm_r <= arm_r | raw_s;
    end
  end

  // State, counters and tick register
  always_ff @(posedge SC_LEVEL_PROGRESS_CLOCK_50 or negedge SC_LEVEL_PROGRESS_RESET_InLow) begin
    if (!SC_LEVEL_PROGRESS_RESET_InLow) begin
      state_r <= IDLE;
      level_r <= 3'd0;
      prog_r  <= 5'd0;
      presc_r <= 26'd0;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      level_r <= level_s;
      prog_r  <= prog_s;
      presc_r <= presc_s;
      tick_r  <= tick_s;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_s = state_r;
    level_s = level_r;
    prog_s  = prog_r;
    presc_s = presc_r;
    tick_s  = 1'b0;
    case (state_r)
      IDLE: begin
        level_s = 3'd0;
        prog_s  = 5'd0;
        presc_s = 26'd0;
        if (ev_s[START]) begin
          state_s = RUN;
          level_s = 3'd1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (halt_s) begin
          state_s = HOLD;
        end else if (advance_s) begin
          level_s = level_sat_inc(level_r);
          prog_s  = 5'd0;
          presc_s = 26'd0;
        end else begin
          presc_s = wrap_s ? 26'd0 : presc_r + 26'd1;
          tick_s  = wrap_s;
          if (wrap_s || ev_s[PU]) begin
            prog_s = prog_sat_inc(prog_r);
          end else begin
            prog_s = prog_r;
          end
        end
      end
      HOLD: begin
        if (ev_s[START]) begin
          state_s = RUN;
          level_s = 3'd1;
          prog_s  = 5'd0;
          presc_s = 26'd0;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
        level_s = 3'd0;
        prog_s  = 5'd0;
        presc_s = 26'd0;
      end
    endcase
  end

  assign SC_LEVEL_PROGRESS_CurrentLevel_Out  = level_r;
  assign SC_LEVEL_PROGRESS_ProgressCount_Out = prog_r;
  assign SC_LEVEL_PROGRESS_Tick_Out          = tick_r;

endmodule

// File: doc/sc_level_progress.md
SC_LEVEL_PROGRESS -- requirements
Module: sc_level_progress

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clock cycles per automatic progress step (legal 2..2^26).
REQ-002 Parameter PROGRESS_MAX, default 31, saturation value of the progress count.
REQ-003 SC_LEVEL_PROGRESS_CLOCK_50  in  1  system clock; all state on rising edge.
REQ-004 SC_LEVEL_PROGRESS_RESET_InLow  in  1  reset, asynchronous, active-low.
REQ-005 SC_LEVEL_PROGRESS_Start_InLow  in  1  game start request, active-low.
REQ-006 SC_LEVEL_PROGRESS_upCount_InLow  in  1  level advance request from the level state machine, active-low, may be held many cycles.
REQ-007 SC_LEVEL_PROGRESS_ProgressUpCount_InLow  in  1  manual progress step request, active-low, may be held.
REQ-008 SC_LEVEL_PROGRESS_LevelEnd_InLow  in  1  level-complete flag, active-low.
REQ-009 SC_LEVEL_PROGRESS_GameEnd_InLow  in  1  game-over flag, active-low.
REQ-010 SC_LEVEL_PROGRESS_CurrentLevel_Out  out  3  current level number, 0..7.
REQ-011 SC_LEVEL_PROGRESS_ProgressCount_Out  out  5  progress within current level, 0..PROGRESS_MAX.
REQ-012 SC_LEVEL_PROGRESS_Tick_Out  out  1  one-cycle high pulse on each automatic progress step.

Function
REQ-013 Each active-low input SHALL pass through a 2-flop sample chain (s1, s2); a request event SHALL be s2==1 and s1==0 (falling edge), one event per assertion regardless of hold length.
REQ-014 Counters SHALL update on the edge after the event is detected: output change visible 2 rising edges after the input is first sampled low.
REQ-015 FSM states: IDLE, RUN, HOLD.
REQ-016 IDLE: level=0, progress=0, prescaler=0; Start event -> level=1, progress=0, go RUN; all other events ignored.
REQ-017 RUN: prescaler SHALL count 0..TICK_DIV-1 and wrap; on wrap Tick_Out=1 for that cycle and progress +1.
REQ-018 RUN: ProgressUpCount event SHALL add 1 to progress; coincident with prescaler wrap, total increment SHALL be 1, not 2.
REQ-019 Progress SHALL saturate at PROGRESS_MAX; Tick_Out still pulses at wrap when saturated.
REQ-020 RUN: upCount event or LevelEnd event SHALL increment level by 1 (saturate at 7), clear progress to 0 and clear prescaler; both events in the same cycle SHALL produce a single increment.
REQ-021 Level advance SHALL take priority over any progress increment in the same cycle (progress ends 0).
REQ-022 RUN: s1 of GameEnd sampled low SHALL move to HOLD at the next edge, regardless of other events that cycle (those are discarded).
REQ-023 HOLD: level, progress and prescaler frozen, Tick_Out=0; Start event -> IDLE values then RUN with level=1 at the following edge (restart).
REQ-024 Tick_Out SHALL be 0 in IDLE and HOLD.
REQ-025 Level 7 reached in RUN SHALL remain RUN; further advance events leave level at 7 and still clear progress.
REQ-026 Prescaler width SHALL be 26 bits; no output SHALL be combinationally dependent on any input.

Reset
REQ-027 RESET_InLow low SHALL immediately force state IDLE, level=0, progress=0, prescaler=0, Tick_Out=0, all sample flops=1 (no spurious edge after release).
REQ-028 Reset asserted mid-operation (any state) SHALL take effect asynchronously; release SHALL be followed by normal IDLE behaviour from the next edge.

Verification (bench uses TICK_DIV=4, PROGRESS_MAX=31)
REQ-029 Reset, Start low 3 cycles -> level 0->1 exactly once, 2 edges after first sampled low; progress 0.
REQ-030 RUN 40 cycles idle -> Tick_Out pulses every 4th cycle, progress 10; continue 100 cycles -> progress holds 31.
REQ-031 upCount held low 20 cycles with LevelEnd falling same cycle -> level +1 only, progress 0, prescaler restarts (next Tick 4 cycles later).
REQ-032 ProgressUpCount falling coincident with prescaler wrap -> progress +1 only; level advance in the same cycle -> progress 0.
REQ-033 GameEnd low in RUN at level 3, progress 9 -> HOLD, values frozen 50 cycles, Tick_Out 0; Start -> level 1, progress 0, RUN.
REQ-034 Reset pulsed mid-RUN with inputs held low -> outputs 0 immediately; after release no level/progress change until an input goes high then low again.
